// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32 fetch types, constants and helpers
package rv32_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;
  localparam word_t NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam int    FETCH_CREDITS    = 2;

  // One buffered fetch result: the address it was issued at and the word returned
  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  // Force an address onto a word boundary
  function automatic word_t word_align(input word_t a);
    return a & ~word_t'(3);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory, hazard, redirect and decode-facing signals
interface fetch_stage_if;
  import rv32_pkg::*;

  // instruction memory request/response
  logic  imem_req_valid;
  logic  imem_req_ready;
  word_t imem_addr;
  logic  imem_rsp_valid;
  word_t imem_rsp_data;

  // pipeline control
  logic  id_stall;
  logic  ex_redirect;
  word_t ex_redirect_pc;

  // IF/ID register towards decode
  logic  id_valid;
  word_t id_instr;
  word_t id_pc;

  // the fetch stage itself
  modport master (
    output imem_req_valid, imem_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  id_stall, ex_redirect, ex_redirect_pc,
    output id_valid, id_instr, id_pc
  );

  // memory, hazard unit, execute and decode around it
  modport slave (
    input  imem_req_valid, imem_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output id_stall, ex_redirect, ex_redirect_pc,
    input  id_valid, id_instr, id_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - two-entry {pc, instr} response buffer with flush
module fetch_fifo
  import rv32_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t slots [2];
  logic         rd_ptr;
  logic         wr_ptr;

  // Pointer and occupancy tracking; flush beats any concurrent push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // Payload storage; contents are only meaningful while counted, so no reset
  always_ff @(posedge clk) begin
    if (push && !flush) slots[wr_ptr] <= push_entry;
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, request credit, stale-response drop and IF/ID register
module fetch_stage
  import rv32_pkg::*;
#(
  parameter word_t RESET_PC  = DEFAULT_RESET_PC,
  parameter int    MAX_OUTST = FETCH_CREDITS
) (
  input logic           clk,
  input logic           rst,
  fetch_stage_if.master bus
);

  word_t        pc;
  logic [1:0]   outst;        // accepted requests not yet answered
  logic [1:0]   drop;         // answers still owed to pre-redirect requests
  word_t        iss_pc [2];   // issue addresses of outstanding requests, oldest first
  logic [1:0]   fifo_count;
  fetch_entry_t fifo_head;
  fetch_entry_t rsp_entry;

  logic         id_valid_q;
  word_t        id_instr_q;
  word_t        id_pc_q;

  logic [2:0]   in_use;
  logic         req_valid;
  logic         req_fire;
  logic         rsp_eff;
  logic         rsp_live;
  logic         fifo_push;
  logic         fifo_pop;
  logic [1:0]   outst_left;

  // A response with nothing outstanding (e.g. a leftover across reset) is ignored
  assign rsp_eff    = bus.imem_rsp_valid && (outst != 2'd0);
  assign rsp_live   = rsp_eff && (drop == 2'd0) && !bus.ex_redirect;
  assign outst_left = outst - {1'b0, rsp_eff};
  assign rsp_entry  = '{pc: iss_pc[0], instr: bus.imem_rsp_data};

  // Credit rule: in-flight plus buffered never exceeds the FIFO depth
  assign in_use    = {1'b0, outst} + {1'b0, fifo_count};
  assign req_valid = !bus.ex_redirect && (in_use < 3'(MAX_OUTST));
  assign req_fire  = req_valid && bus.imem_req_ready;

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_addr      = pc;

  // Buffer a live response unless it can go straight into IF/ID this cycle
  assign fifo_push = rsp_live && (bus.id_stall || (fifo_count != 2'd0));
  assign fifo_pop  = !bus.ex_redirect && !bus.id_stall && (fifo_count != 2'd0);

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_entry (rsp_entry),
    .pop        (fifo_pop),
    .flush      (bus.ex_redirect),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  // Program counter: redirect target, else advance on an accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= word_align(RESET_PC);
    end else if (bus.ex_redirect) begin
      pc <= word_align(bus.ex_redirect_pc);
    end else if (req_fire) begin
      pc <= pc + 32'd4;
    end
  end

  // Outstanding count and the number of stale answers still to swallow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outst <= 2'd0;
      drop  <= 2'd0;
    end else begin
      outst <= outst_left + {1'b0, req_fire};
      if (bus.ex_redirect) begin
        drop <= outst_left;
      end else if (rsp_eff && (drop != 2'd0)) begin
        drop <= drop - 2'd1;
      end
    end
  end

  // Issue-address queue: shift on every answer, append the address on fire
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_pc[0] <= '0;
      iss_pc[1] <= '0;
    end else begin
      if (rsp_eff) iss_pc[0] <= iss_pc[1];
      if (req_fire) iss_pc[outst_left[0]] <= pc;
    end
  end

  // IF/ID register: redirect, then stall, then FIFO head, then bypass
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q <= 1'b0;
      id_instr_q <= NOP_INSTR;
      id_pc_q    <= '0;
    end else if (bus.ex_redirect) begin
      id_valid_q <= 1'b0;
    end else if (bus.id_stall) begin
      id_valid_q <= id_valid_q;
    end else if (fifo_count != 2'd0) begin
      id_valid_q <= 1'b1;
      id_instr_q <= fifo_head.instr;
      id_pc_q    <= fifo_head.pc;
    end else if (rsp_live) begin
      id_valid_q <= 1'b1;
      id_instr_q <= rsp_entry.instr;
      id_pc_q    <= rsp_entry.pc;
    end else begin
      id_valid_q <= 1'b0;
    end
  end

  assign bus.id_valid = id_valid_q;
  assign bus.id_instr = id_instr_q;
  assign bus.id_pc    = id_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized fetch stage bench with a program-order reference model
module tb_fetch_stage;
  import rv32_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .MAX_OUTST(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // memory side: accepted requests in order, each tagged with the redirect epoch it belongs to
  typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  mreq_t       mem_q[$];
  ent_t        fq[$];          // delivered, not yet handed to decode
  logic [31:0] m_pc;
  bit          m_id_valid;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_instr;
  int          epoch;
  int          cyc;

  bit          k_ready, k_stall, k_redir, k_spurious;
  logic [31:0] k_rpc;
  int          k_lat_min, k_lat_max, k_rsp_pct;

  int          total;
  int          bad;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mem_q.delete();
    fq.delete();
    m_pc       = 32'h0000_0000;
    m_id_valid = 1'b0;
    epoch++;
  endtask

  // one clock: drive at negedge, compare against the model, advance the model
  task automatic cycle();
    bit    rsp, live, exp_rv, m_fire, act_fire;
    mreq_t e;
    ent_t  h;
    @(negedge clk);
    rst = 1'b0;
    bus.imem_req_ready = k_ready;
    bus.id_stall       = k_stall;
    bus.ex_redirect    = k_redir;
    bus.ex_redirect_pc = k_rpc;
    rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc) && ($urandom_range(99) < k_rsp_pct);
    bus.imem_rsp_valid = rsp || (k_spurious && mem_q.size() == 0);
    bus.imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
    #1;
    exp_rv = !k_redir && ((mem_q.size() + fq.size()) < 2);
    chk("req_valid", bus.imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", bus.imem_addr, m_pc);
    chk("id_valid", bus.id_valid, m_id_valid);
    if (m_id_valid) begin
      chk("id_pc", bus.id_pc, m_id_pc);
      chk("id_instr", bus.id_instr, m_id_instr);
    end
    m_fire   = exp_rv && k_ready;
    act_fire = bus.imem_req_valid && k_ready;
    live     = 1'b0;
    if (rsp) begin
      e    = mem_q.pop_front();
      live = (e.epoch == epoch) && !k_redir;
    end
    if (act_fire)
      mem_q.push_back('{addr: bus.imem_addr, epoch: epoch,
                        due: cyc + $urandom_range(k_lat_max, k_lat_min)});
    if (k_redir) begin
      epoch++;
      fq.delete();
      m_id_valid = 1'b0;
      m_pc = {k_rpc[31:2], 2'b00};
    end else begin
      if (live) fq.push_back('{pc: e.addr, instr: mem_word(e.addr)});
      if (!k_stall) begin
        if (fq.size() > 0) begin
          h = fq.pop_front();
          m_id_valid = 1'b1;
          m_id_pc    = h.pc;
          m_id_instr = h.instr;
        end else begin
          m_id_valid = 1'b0;
        end
      end
      if (m_fire) m_pc = m_pc + 32'd4;
    end
    cyc++;
    @(posedge clk);
  endtask

  // asynchronous reset asserted between clock edges, with garbage responses pending
  task automatic do_reset(input int hold);
    @(negedge clk);
    #2;
    rst = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD0_BAD0;
    #1;
    chk("rst_id_valid", bus.id_valid, 1'b0);
    chk("rst_id_instr", bus.id_instr, 32'h0000_0013);
    chk("rst_id_pc", bus.id_pc, 32'h0000_0000);
    chk("rst_addr", bus.imem_addr, 32'h0000_0000);
    model_reset();
    repeat (hold) @(posedge clk);
  endtask

  task automatic wait_outst2(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = (mem_q.size() == 2);
    end
    chk(nm, got, 1'b1);
  endtask

  task automatic wait_id_valid(input string nm);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      cycle();
      #1;
      got = bus.id_valid;
    end
    chk(nm, got, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total = 0; bad = 0; epoch = 0; cyc = 0;
    bus.imem_req_ready = 1'b0; bus.id_stall = 1'b0; bus.ex_redirect = 1'b0;
    bus.ex_redirect_pc = '0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    k_ready = 1'b1; k_stall = 1'b0; k_redir = 1'b0; k_spurious = 1'b0; k_rpc = '0;
    k_lat_min = 1; k_lat_max = 1; k_rsp_pct = 100;

    // reset, then a 1-cycle memory streaming 0x0, 0x4, 0x8 ...
    do_reset(2);
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (k >= 1 && k <= 3) begin
        #1;
        chk("seq_valid", bus.id_valid, 1'b1);
        chk("seq_pc", bus.id_pc, 32'(4 * (k - 1)));
      end
    end

    // stall for 3 cycles with the stream flowing, then drain
    k_stall = 1'b1;
    repeat (3) cycle();
    k_stall = 1'b0;
    repeat (6) cycle();

    // redirect to 0x100 with two requests in flight
    k_lat_min = 3; k_lat_max = 3;
    wait_outst2("outst2_before_redirect");
    k_redir = 1'b1; k_rpc = 32'h0000_0100;
    cycle();
    k_redir = 1'b0; k_lat_min = 1; k_lat_max = 1;
    wait_id_valid("redirect_target_arrives");
    chk("redirect_pc", bus.id_pc, 32'h0000_0100);
    chk("redirect_instr", bus.id_instr, mem_word(32'h0000_0100));
    repeat (3) cycle();

    // redirect and stall together, misaligned target
    k_stall = 1'b1; k_redir = 1'b1; k_rpc = 32'h0000_0102;
    cycle();
    #1;
    chk("redir_stall_id_valid", bus.id_valid, 1'b0);
    chk("redir_misaligned_addr", bus.imem_addr, 32'h0000_0100);
    k_stall = 1'b0; k_redir = 1'b0;
    repeat (5) cycle();

    // memory not ready for 4 cycles after a redirect to 0x200
    k_redir = 1'b1; k_rpc = 32'h0000_0200; k_ready = 1'b0;
    cycle();
    k_redir = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      #1;
      chk("hold_addr", bus.imem_addr, 32'h0000_0200);
    end
    k_ready = 1'b1;
    repeat (4) cycle();

    // randomized traffic: ready, stall, redirect, latency and response gaps
    k_lat_min = 1; k_lat_max = 3; k_rsp_pct = 70;
    for (int k = 0; k < 400; k++) begin
      k_ready = ($urandom_range(3) != 0);
      k_stall = ($urandom_range(4) == 0);
      k_redir = ($urandom_range(19) == 0);
      k_rpc   = $urandom();
      cycle();
    end
    k_ready = 1'b1; k_stall = 1'b0; k_redir = 1'b0; k_rsp_pct = 100;

    // reset pulse mid-stream with two outstanding; late response after release
    k_lat_min = 3; k_lat_max = 3;
    wait_outst2("outst2_before_reset");
    do_reset(2);
    k_lat_min = 1; k_lat_max = 1; k_spurious = 1'b1;
    cycle();
    k_spurious = 1'b0;
    wait_id_valid("refetch_arrives");
    chk("refetch_pc", bus.id_pc, 32'h0000_0000);
    chk("refetch_instr", bus.id_instr, mem_word(32'h0000_0000));
    repeat (6) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
